// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg
//   Shared definitions for the FIFO read-side controller.
//   - rd_state_t : controller state (IDLE, RUN, DRAIN)
//   - BUF_DEPTH  : entries in the output buffer (fixed at 2)
package fifo_rd_pkg;

  localparam int BUF_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;

endpackage

// File: rtl/fifo_rd_skid.sv
// fifo_rd_skid
//   Two-entry in-order buffer. Push and pop may occur in the same cycle;
//   order is preserved and occupancy is unchanged in that case. The
//   caller guarantees it never pushes into a full buffer nor pops an
//   empty one.
// Ports:
//   clk  : clock, rising edge
//   res  : asynchronous active-low reset (clears occupancy only)
//   push : write din into the tail this cycle
//   din  : data to push
//   pop  : remove the head this cycle
//   head : oldest entry, forced to 0 while empty
//   occ  : number of entries held (0..2)
module fifo_rd_skid
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             res,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       occ
);
  import fifo_rd_pkg::*;

  localparam logic [1:0] FULL = 2'(BUF_DEPTH);

  logic [1:0]       occ_q;
  logic [WIDTH-1:0] ent0_q;
  logic [WIDTH-1:0] ent1_q;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // Data entries carry no reset; an empty buffer presents 0 on head.
  always_ff @(posedge clk) begin
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) ent0_q <= din;
        else               ent1_q <= din;
      end
      2'b01: begin
        ent0_q <= ent1_q;
      end
      2'b11: begin
        // Head leaves while a new word arrives: shift then append.
        if (occ_q == FULL) begin
          ent0_q <= ent1_q;
          ent1_q <= din;
        end else begin
          ent0_q <= din;
        end
      end
      default: ;
    endcase
  end

  assign head = (occ_q != 2'd0) ? ent0_q : '0;
  assign occ  = occ_q;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl
//   Read-side controller for the synchronous FIFO. Pops the FIFO through
//   its read port, absorbs the one-cycle registered read latency and
//   presents words on a valid/ready stream. Never pops an empty FIFO.
//   Pop-to-stream latency is 2 cycles; full throughput with m_ready=1.
// Configuration:
//   FIFO_RD_CNT_EN : when defined, rd_count counts stream transfers
//                    (wraps, cleared only by reset); otherwise tied to 0.
// Ports:
//   clk        : clock, rising edge
//   res        : asynchronous active-low reset
//   enable     : allow new pops; 0 drains what is already fetched
//   fifo_empty : FIFO empty flag
//   fifo_rdata : FIFO registered read data
//   fifo_rd_en : FIFO read enable (combinational)
//   m_valid    : stream valid
//   m_ready    : stream ready from downstream
//   m_data     : stream data
//   busy       : a word is in flight or buffered
//   rd_count   : delivered-word counter
module fifo_rd_ctrl
#(
  parameter int WIDTH     = 8,
  parameter int BUF_DEPTH = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic                 enable,
  input  logic                 fifo_empty,
  input  logic [WIDTH-1:0]     fifo_rdata,
  output logic                 fifo_rd_en,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [WIDTH-1:0]     m_data,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] rd_count
);
  import fifo_rd_pkg::*;

  rd_state_t  state_q;
  logic       inflight_p1;
  logic [1:0] occ;
  logic       xfer;
  logic       held;
  logic [2:0] held_cnt;
  logic [2:0] pop_limit;

  assign xfer = m_valid & m_ready;
  assign held = (occ != 2'd0) | inflight_p1;

  // Words held or in flight must stay below the buffer size, plus one slot
  // freed by a transfer this cycle. The m_ready term is combinational so a
  // full buffer can keep streaming one word per cycle. res gates the pop so
  // the FIFO sees no read while reset is asserted.
  assign held_cnt   = {1'b0, occ} + {2'b00, inflight_p1};
  assign pop_limit  = 3'(BUF_DEPTH) + {2'b00, xfer};
  assign fifo_rd_en = res & enable & ~fifo_empty & (held_cnt < pop_limit);

  // Stage p1: FIFO rdata is valid the cycle after a pop.
  always_ff @(posedge clk or negedge res) begin
    if (!res) inflight_p1 <= 1'b0;
    else      inflight_p1 <= fifo_rd_en;
  end

  // Stage p2: captured word becomes visible on the stream.
  fifo_rd_skid #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk  (clk),
    .res  (res),
    .push (inflight_p1),
    .din  (fifo_rdata),
    .pop  (xfer),
    .head (m_data),
    .occ  (occ)
  );

  assign m_valid = (occ != 2'd0);
  assign busy    = held;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE:    if (enable) state_q <= RUN;
        RUN:     if (!enable) state_q <= held ? DRAIN : IDLE;
        DRAIN: begin
          if (enable)     state_q <= RUN;
          else if (!held) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef FIFO_RD_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or negedge res) begin
    if (!res)      cnt_q <= '0;
    else if (xfer) cnt_q <= cnt_q + 1'b1;
  end

  assign rd_count = cnt_q;
`else
  assign rd_count = '0;
`endif

endmodule

// File: doc/fifo_rd_ctrl.md
# fifo_rd_ctrl

Read-side controller for the team's synchronous FIFO. It drains the FIFO through its read port (`rd_en`, registered `rdata`, `empty`), absorbs the one-cycle read latency, and presents the words on a valid/ready stream. It never pops an empty FIFO, so the FIFO's `underflow` flag stays low. It sits between the FIFO and any downstream consumer that can apply backpressure.

## Interface
Parameters:
- `WIDTH`, 8: data word width; must match the FIFO's `WIDTH`.
- `BUF_DEPTH`, 2: output buffer entries; fixed at 2.
- `CNT_WIDTH`, 16: width of the delivered-word counter.

Ports:
- `clk` input 1: single clock; all logic is on the rising edge.
- `res` input 1: asynchronous, active-low reset.
- `enable` input 1: 1 allows new FIFO pops; 0 stops new pops and drains what is already fetched.
- `fifo_empty` input 1: FIFO `empty` output.
- `fifo_rdata` input WIDTH: FIFO `rdata` output.
- `fifo_rd_en` output 1: FIFO `rd_en` input. Combinational.
- `m_valid` output 1: stream data valid.
- `m_ready` input 1: downstream accepts the current word.
- `m_data` output WIDTH: stream data.
- `busy` output 1: a word is in flight or buffered.
- `rd_count` output CNT_WIDTH: number of words delivered (see Configuration).

## Operation
- `inflight` register: 1 in the cycle after a pop, while `fifo_rdata` holds the popped word.
- Buffer is a 2-entry FIFO with occupancy `occ` (0..2).
  - Capture `fifo_rdata` into the buffer when `inflight`=1.
  - Head of the buffer drives `m_data`; `m_valid` = (`occ` != 0).
- Handshake: a word transfers when `m_valid & m_ready`.
  - While `m_valid`=1 and `m_ready`=0, `m_data` and `m_valid` hold stable.
- Pop rule: `fifo_rd_en` = `enable` & !`fifo_empty` & (`occ` + `inflight` < 2 + (`m_valid` & `m_ready`)).
  - This never overflows the buffer, even with a simultaneous capture and transfer.
- Simultaneous capture and transfer: `occ` is unchanged and the order is preserved.
- States (`rd_state_t`):
  - IDLE: `enable`=0 and nothing held. Go to RUN when `enable`=1.
  - RUN: pops are allowed. Go to DRAIN when `enable`=0 and (`occ` | `inflight`) != 0. Go to IDLE when `enable`=0 and nothing is held.
  - DRAIN: no pops. Go to IDLE when `occ`=0 and `inflight`=0. Go to RUN when `enable` returns to 1.
- `busy` = (`occ` != 0) | `inflight`.
- Reset values: `fifo_rd_en`=0, `m_valid`=0, `m_data`=0, `busy`=0, `rd_count`=0, state IDLE.
- Reset mid-operation: buffered and in-flight words are discarded. The FIFO is reset by its own reset.

## Timing
- Pop issued in cycle N, when `fifo_rd_en`=1 at edge N.
  - `fifo_rdata` is valid in cycle N+1, with `inflight`=1.
  - The word is captured at edge N+1.
  - `m_valid`=1 in cycle N+2.
- Latency from pop to stream is 2 cycles.
- Throughput is 1 word per cycle in steady state when `m_ready`=1 and the FIFO is non-empty.
- Path from `m_ready` to `fifo_rd_en` is combinational. This path is intentional and required for full throughput.
- A FIFO holding one word asserts `empty` in the cycle after it is popped, so no second pop is issued.
- Wrap-around: `rd_count` wraps modulo 2^CNT_WIDTH with no flag.

## Configuration
- `FIFO_RD_CNT_EN` defined:
  - `rd_count` increments by 1 on every stream transfer.
  - It clears only on reset.
- `FIFO_RD_CNT_EN` undefined:
  - No counter is built.
  - The `rd_count` port remains and is tied to 0.

## Structure
- Package `fifo_rd_pkg`: `rd_state_t` enum (IDLE, RUN, DRAIN) and the `BUF_DEPTH` constant.
- Sub-module `fifo_rd_skid`: the 2-entry buffer with push, pop, head data and `occ` outputs. It has no knowledge of the FIFO protocol.
- `fifo_rd_ctrl` contains the pop rule, the `inflight` register, the FSM and the counter.

## Test plan
- Reset, then write 0x11,0x22,0x33 into the FIFO, `enable`=1, `m_ready`=1 → first `m_valid` 2 cycles after the first pop; stream 0x11,0x22,0x33 on consecutive cycles; FIFO `underflow` stays 0; `rd_count`=3 (with macro).
- FIFO filled with 16 words, `m_ready`=0 → exactly 2 pops then `fifo_rd_en`=0; `m_data`=first word stable; raise `m_ready` → all 16 words in order with no bubble after restart.
- `m_ready` toggling 1,0,1,0 with 8 words queued → no loss or duplication; order preserved; `occ` never exceeds 2.
- Drop `enable` one cycle after a pop with 1 word buffered → state DRAIN, both words delivered, no further pops, `busy` falls, state IDLE.
- Assert `res`=0 asynchronously mid-stream with `occ`=2 → `m_valid`, `busy`, `fifo_rd_en` and `rd_count` go to 0 immediately; after release, state is IDLE.
- Build without `FIFO_RD_CNT_EN` and stream 5 words → `rd_count` stays 0; data path identical.
